// File: rtl/xnor_pkg.sv
// Shared types and helpers for the shared XNOR comparator and its arbiter.
package xnor_pkg;

  // Largest requester count the search helpers cover, and the width of an index.
  localparam int MAX_N  = 32;
  localparam int MAX_IW = 5;
  localparam int CNT_W  = MAX_IW + 1;

  typedef logic [MAX_N-1:0]  vec_t;
  typedef logic [MAX_IW-1:0] idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RESULT
  } state_e;

  // One-hot vector with bit idx set; all zero when idx is outside 0..n-1.
  function automatic vec_t onehot(input idx_t idx, input cnt_t n);
    onehot = '0;
    if ({1'b0, idx} < n) onehot[idx] = 1'b1;
  endfunction

  // First set bit of req searching ptr, ptr+1, ... with wrap at n.
  // Scans downward so the nearest hit to ptr is the last one written.
  // Result is meaningless when req has no bit set below n.
  function automatic idx_t rr_pick(input vec_t req, input idx_t ptr, input cnt_t n);
    cnt_t pos;
    rr_pick = '0;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + cnt_t'(k);
      if (pos >= n) pos = pos - n;
      if ((cnt_t'(k) < n) && req[pos[MAX_IW-1:0]]) rr_pick = pos[MAX_IW-1:0];
    end
  endfunction

endpackage

// File: rtl/xnor_cmp_arbiter_rr_arbiter.sv
// Round-robin pick with a rotating priority pointer. The pointer moves to
// one past the winner whenever the caller commits a grant.
module rr_arbiter
  import xnor_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [IDW-1:0] pick
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  assign pick = IDW'(rr_pick(vec_t'(req), idx_t'(ptr_q), cnt_t'(N)));

  // Next pointer: the just-served requester drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (pick == IDW'(N - 1)) ptr_d = '0;
      else                     ptr_d = pick + 1'b1;
    end
  end

  // Pointer register with synchronous reset.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xnor_cmp_arbiter.sv
// Shares one W-bit XNOR comparator between N requesters in round-robin
// order and holds each registered result until the consumer acknowledges it.
module xnor_cmp_arbiter
  import xnor_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] A_IN,
  input  logic [N*W-1:0] B_IN,
  input  logic           ACK,
  output logic [N-1:0]   GNT,
  output logic [W-1:0]   O,
  output logic           EQ,
  output logic [IDW-1:0] ID,
  output logic           VALID,
  output logic           BUSY
);

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] idx_q, idx_d;
  logic [W-1:0]   o_q, o_d;
  logic           eq_q, eq_d;
  logic [IDW-1:0] id_q, id_d;
  logic           valid_q, valid_d;

  logic           arb;
  logic [IDW-1:0] pick;
  logic [W-1:0]   a_sel, b_sel, xnor_res;

  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .req     (REQ),
    .advance (arb),
    .pick    (pick)
  );

  // Operands of the latched winner feed the single shared comparator.
  assign a_sel    = A_IN[idx_q*W +: W];
  assign b_sel    = B_IN[idx_q*W +: W];
  assign xnor_res = a_sel ~^ b_sel;

  // Next-state and result logic; arbitration from IDLE or an acked RESULT.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    idx_d   = idx_q;
    o_d     = o_q;
    eq_d    = eq_q;
    id_d    = id_q;
    valid_d = valid_q;
    arb     = 1'b0;
    unique case (state_q)
      IDLE:   arb = |REQ;
      GRANT: begin
        state_d = RESULT;
        o_d     = xnor_res;
        eq_d    = &xnor_res;
        id_d    = idx_q;
        valid_d = 1'b1;
      end
      RESULT: begin
        if (ACK) begin
          valid_d = 1'b0;
          if (|REQ) arb = 1'b1;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      state_d = GRANT;
      gnt_d   = N'(onehot(idx_t'(pick), cnt_t'(N)));
      idx_d   = pick;
    end
  end

  // State and result registers; reset discards any result in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      o_q     <= '0;
      eq_q    <= 1'b0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      o_q     <= o_d;
      eq_q    <= eq_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  assign GNT   = gnt_q;
  assign O     = o_q;
  assign EQ    = eq_q;
  assign ID    = id_q;
  assign VALID = valid_q;
  assign BUSY  = (state_q != IDLE);

endmodule
